// File: rtl/instruction_decode_stage_pkg.sv
// Shared decode constants: opcodes, control field layout and the bubble control word.
package decode_pkg;

    localparam int unsigned OPCODE_WIDTH = 6;
    localparam int unsigned WB_WIDTH     = 2;
    localparam int unsigned MEM_WIDTH    = 2;
    localparam int unsigned EX_WIDTH     = 4;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'b001000;

    // Bit positions inside each control field: wb={regWrite,memToReg}, mem={memRead,memWrite},
    // ex={regDst,aluSrc,aluOp[1:0]}.
    localparam int unsigned WB_REG_WRITE_BIT = 1;
    localparam int unsigned MEM_READ_BIT     = 1;
    localparam int unsigned EX_REG_DST_BIT   = 3;

    typedef struct packed {
        logic [WB_WIDTH-1:0]  wb;
        logic [MEM_WIDTH-1:0] mem;
        logic [EX_WIDTH-1:0]  ex;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/instruction_decode_stage_if.sv
// ID-stage bus: IF/ID inputs, write-back and EX/MEM forwarding inputs, ID/EX and hazard outputs.
interface instruction_decode_stage_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    logic                      ifIdValid;
    logic [DATA_WIDTH-1:0]     programCounterIn;
    logic [31:0]               instruction;
    logic                      stallIn;
    logic [REG_ADDR_WIDTH-1:0] writeRegister;
    logic [DATA_WIDTH-1:0]     writeData;
    logic                      regWrite;
    logic                      exMemRegWrite;
    logic [REG_ADDR_WIDTH-1:0] exMemRd;
    logic [DATA_WIDTH-1:0]     exMemResult;

    logic                      idExValid;
    logic [1:0]                writeBackControl;
    logic [1:0]                memAccessControl;
    logic [3:0]                calculationControl;
    logic [DATA_WIDTH-1:0]     programCounterOut;
    logic [DATA_WIDTH-1:0]     readData1;
    logic [DATA_WIDTH-1:0]     readData2;
    logic [DATA_WIDTH-1:0]     immediateOperand;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      pcWrite;
    logic                      ifIdWrite;
    logic                      branch;
    logic [DATA_WIDTH-1:0]     branchProgramCounter;

    modport master (
        output ifIdValid, programCounterIn, instruction, stallIn,
               writeRegister, writeData, regWrite,
               exMemRegWrite, exMemRd, exMemResult,
        input  idExValid, writeBackControl, memAccessControl, calculationControl,
               programCounterOut, readData1, readData2, immediateOperand,
               rs, rt, rd, pcWrite, ifIdWrite, branch, branchProgramCounter
    );

    modport slave (
        input  ifIdValid, programCounterIn, instruction, stallIn,
               writeRegister, writeData, regWrite,
               exMemRegWrite, exMemRd, exMemResult,
        output idExValid, writeBackControl, memAccessControl, calculationControl,
               programCounterOut, readData1, readData2, immediateOperand,
               rs, rt, rd, pcWrite, ifIdWrite, branch, branchProgramCounter
    );

endinterface

// File: rtl/instruction_decode_stage_control.sv
// Combinational opcode-to-control table with branch and BNE decode.
module decode_control
    import decode_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode_i,
    output ctrl_t                   ctrl_o,
    output logic                    is_branch_o,
    output logic                    is_bne_o
);

    // Unknown opcodes fall through to all-zero controls and execute as a NOP.
    always_comb begin
        ctrl_o      = CTRL_BUBBLE;
        is_branch_o = 1'b0;
        is_bne_o    = 1'b0;
        case (opcode_i)
            OP_RTYPE: ctrl_o = '{wb: 2'b10, mem: 2'b00, ex: 4'b1010};
            OP_LW:    ctrl_o = '{wb: 2'b11, mem: 2'b10, ex: 4'b0100};
            OP_SW:    ctrl_o = '{wb: 2'b00, mem: 2'b01, ex: 4'b0100};
            OP_ADDI:  ctrl_o = '{wb: 2'b10, mem: 2'b00, ex: 4'b0110};
            OP_BEQ: begin
                ctrl_o      = '{wb: 2'b00, mem: 2'b00, ex: 4'b0001};
                is_branch_o = 1'b1;
            end
            OP_BNE: begin
                ctrl_o      = '{wb: 2'b00, mem: 2'b00, ex: 4'b0001};
                is_branch_o = 1'b1;
                is_bne_o    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_decode_stage_regfile.sv
// Two-read one-write register file; register 0 is hardwired to zero and reads see same-cycle writes.
module register_file_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_live;

    assign wr_live = we_i && (waddr_i != '0);

    always_ff @(posedge clk) begin
        if (wr_live) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = mem_q[raddr1_i];
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (wr_live && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = mem_q[raddr2_i];
        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (wr_live && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// Pipeline ID stage: operand read, control decode, ID-resolved BEQ/BNE, hazard stall and ID/EX register.
module instruction_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned IMM_WIDTH      = 16,
    parameter int unsigned BRANCH_SHIFT   = 2
) (
    input logic                        clk,
    input logic                        reset,
    instruction_decode_stage_if.slave  id_bus
);

    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [REG_ADDR_WIDTH-1:0] cur_rs;
    logic [REG_ADDR_WIDTH-1:0] cur_rt;
    logic [REG_ADDR_WIDTH-1:0] cur_rd;
    logic [IMM_WIDTH-1:0]      imm_raw;
    logic [DATA_WIDTH-1:0]     imm_ext;

    assign opcode  = id_bus.instruction[31:26];
    assign cur_rs  = REG_ADDR_WIDTH'(id_bus.instruction[25:21]);
    assign cur_rt  = REG_ADDR_WIDTH'(id_bus.instruction[20:16]);
    assign cur_rd  = REG_ADDR_WIDTH'(id_bus.instruction[15:11]);
    assign imm_raw = id_bus.instruction[IMM_WIDTH-1:0];
    assign imm_ext = DATA_WIDTH'($signed(imm_raw));

    ctrl_t dec_ctrl;
    logic  is_branch;
    logic  is_bne;

    decode_control u_control (
        .opcode_i    (opcode),
        .ctrl_o      (dec_ctrl),
        .is_branch_o (is_branch),
        .is_bne_o    (is_bne)
    );

    logic [DATA_WIDTH-1:0] rf_rd1;
    logic [DATA_WIDTH-1:0] rf_rd2;

    register_file_param #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_regfile (
        .clk      (clk),
        .we_i     (id_bus.regWrite),
        .waddr_i  (id_bus.writeRegister),
        .wdata_i  (id_bus.writeData),
        .raddr1_i (cur_rs),
        .raddr2_i (cur_rt),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2)
    );

    logic                      valid_q, valid_d;
    ctrl_t                     ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]     pc_q, pc_d;
    logic [DATA_WIDTH-1:0]     rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0]     rd2_q, rd2_d;
    logic [DATA_WIDTH-1:0]     imm_q, imm_d;
    logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d;
    logic [REG_ADDR_WIDTH-1:0] rt_q, rt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      flush_q, flush_d;

    // Branch compare operands take the EX/MEM result when it targets a nonzero source.
    logic                  fwd_a;
    logic                  fwd_b;
    logic [DATA_WIDTH-1:0] cmp_a;
    logic [DATA_WIDTH-1:0] cmp_b;
    logic                  cmp_eq;

    assign fwd_a  = id_bus.exMemRegWrite && (id_bus.exMemRd != '0) && (id_bus.exMemRd == cur_rs);
    assign fwd_b  = id_bus.exMemRegWrite && (id_bus.exMemRd != '0) && (id_bus.exMemRd == cur_rt);
    assign cmp_a  = fwd_a ? id_bus.exMemResult : rf_rd1;
    assign cmp_b  = fwd_b ? id_bus.exMemResult : rf_rd2;
    assign cmp_eq = (cmp_a == cmp_b);

    // A flushed or invalid slot never raises a hazard or a branch.
    logic                      slot_live;
    logic                      load_use;
    logic [REG_ADDR_WIDTH-1:0] ex_dest;
    logic                      branch_alu;
    logic                      hazard;
    logic                      taken;
    logic                      branch_c;
    logic                      issue;

    assign slot_live  = id_bus.ifIdValid && !flush_q;
    assign load_use   = valid_q && ctrl_q.mem[MEM_READ_BIT] && (rt_q != '0)
                        && ((rt_q == cur_rs) || (rt_q == cur_rt));
    assign ex_dest    = ctrl_q.ex[EX_REG_DST_BIT] ? rd_q : rt_q;
    assign branch_alu = is_branch && valid_q && ctrl_q.wb[WB_REG_WRITE_BIT] && (ex_dest != '0)
                        && ((ex_dest == cur_rs) || (ex_dest == cur_rt));
    assign hazard     = slot_live && (load_use || branch_alu);
    assign taken      = is_branch && (is_bne ? !cmp_eq : cmp_eq);
    assign branch_c   = taken && slot_live && !hazard && !id_bus.stallIn;
    assign issue      = slot_live && !hazard;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        flush_d = flush_q;
        if (!id_bus.stallIn) begin
            valid_d = issue;
            ctrl_d  = issue ? dec_ctrl : CTRL_BUBBLE;
            pc_d    = id_bus.programCounterIn;
            rd1_d   = rf_rd1;
            rd2_d   = rf_rd2;
            imm_d   = imm_ext;
            rs_d    = cur_rs;
            rt_d    = cur_rt;
            rd_d    = cur_rd;
            flush_d = branch_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            flush_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            flush_q <= flush_d;
        end
    end

    assign id_bus.idExValid            = valid_q;
    assign id_bus.writeBackControl     = ctrl_q.wb;
    assign id_bus.memAccessControl     = ctrl_q.mem;
    assign id_bus.calculationControl   = ctrl_q.ex;
    assign id_bus.programCounterOut    = pc_q;
    assign id_bus.readData1            = rd1_q;
    assign id_bus.readData2            = rd2_q;
    assign id_bus.immediateOperand     = imm_q;
    assign id_bus.rs                   = rs_q;
    assign id_bus.rt                   = rt_q;
    assign id_bus.rd                   = rd_q;
    assign id_bus.pcWrite              = !id_bus.stallIn && !hazard;
    assign id_bus.ifIdWrite            = !id_bus.stallIn && !hazard;
    assign id_bus.branch               = branch_c;
    assign id_bus.branchProgramCounter = id_bus.programCounterIn + (imm_ext << BRANCH_SHIFT);

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for the ID stage: reset, hazards, branch resolution, write-through and stall.
module tb_instruction_decode_stage;
    import decode_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    instruction_decode_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    instruction_decode_stage #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .IMM_WIDTH      (16),
        .BRANCH_SHIFT   (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .id_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] s, logic [4:0] t, logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] enc_r(logic [4:0] s, logic [4:0] t, logic [4:0] d);
        return {OP_RTYPE, s, t, d, 5'd0, 6'b100000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(logic v, logic [31:0] instr, logic [31:0] pc);
        bus.ifIdValid        = v;
        bus.instruction      = instr;
        bus.programCounterIn = pc;
    endtask

    task automatic idle(int n);
        drive(1'b0, 32'h0, 32'h0);
        bus.exMemRegWrite = 1'b0;
        bus.regWrite      = 1'b0;
        bus.stallIn       = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_reg(logic [4:0] r, logic [31:0] d);
        bus.regWrite      = 1'b1;
        bus.writeRegister = r;
        bus.writeData     = d;
        tick();
        bus.regWrite      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, $urandom, 32'h1234);
        tick();
        tick();
        total++; if (bus.idExValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", bus.idExValid); end
        total++; if ({bus.writeBackControl, bus.memAccessControl, bus.calculationControl} !== 8'h00) begin bad++;
            $display("FAIL reset_ctrl got=%0h exp=0", {bus.writeBackControl, bus.memAccessControl, bus.calculationControl}); end
        total++; if ({bus.programCounterOut, bus.readData1, bus.readData2, bus.immediateOperand} !== 128'h0) begin bad++;
            $display("FAIL reset_data got=%0h exp=0", {bus.programCounterOut, bus.readData1, bus.readData2, bus.immediateOperand}); end
        total++; if ({bus.rs, bus.rt, bus.rd} !== 15'h0) begin bad++; $display("FAIL reset_regs got=%0h exp=0", {bus.rs, bus.rt, bus.rd}); end
        reset = 1'b0;
        drive(1'b1, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5), 32'h100);
        tick();
        total++; if (bus.calculationControl !== 4'b0110) begin bad++; $display("FAIL addi_calc got=%b exp=0110", bus.calculationControl); end
        total++; if (bus.immediateOperand !== 32'd5) begin bad++; $display("FAIL addi_imm got=%0h exp=5", bus.immediateOperand); end
        total++; if (bus.idExValid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0h exp=1", bus.idExValid); end
        total++; if ({bus.writeBackControl, bus.rt, bus.programCounterOut} !== {2'b10, 5'd1, 32'h100}) begin bad++;
            $display("FAIL addi_fields got=%0h exp=%0h", {bus.writeBackControl, bus.rt, bus.programCounterOut}, {2'b10, 5'd1, 32'h100}); end
    endtask

    task automatic test_load_use();
        idle(1);
        drive(1'b1, enc_i(OP_LW, 5'd1, 5'd2, 16'd0), 32'h104);
        tick();
        total++; if ({bus.idExValid, bus.memAccessControl} !== 3'b110) begin bad++;
            $display("FAIL lw_issue got=%b exp=110", {bus.idExValid, bus.memAccessControl}); end
        drive(1'b1, enc_r(5'd2, 5'd4, 5'd3), 32'h108);
        settle();
        total++; if ({bus.pcWrite, bus.ifIdWrite} !== 2'b00) begin bad++; $display("FAIL lu_stall got=%b exp=00", {bus.pcWrite, bus.ifIdWrite}); end
        tick();
        total++; if ({bus.idExValid, bus.writeBackControl, bus.memAccessControl, bus.calculationControl} !== 9'h0) begin bad++;
            $display("FAIL lu_bubble got=%0h exp=0", {bus.idExValid, bus.writeBackControl, bus.memAccessControl, bus.calculationControl}); end
        total++; if ({bus.pcWrite, bus.ifIdWrite} !== 2'b11) begin bad++; $display("FAIL lu_release got=%b exp=11", {bus.pcWrite, bus.ifIdWrite}); end
        tick();
        total++; if ({bus.idExValid, bus.calculationControl, bus.rd} !== {1'b1, 4'b1010, 5'd3}) begin bad++;
            $display("FAIL lu_add_issue got=%0h exp=%0h", {bus.idExValid, bus.calculationControl, bus.rd}, {1'b1, 4'b1010, 5'd3}); end
    endtask

    task automatic test_beq_forward();
        idle(1);
        wr_reg(5'd5, 32'd7);
        wr_reg(5'd6, 32'd3);
        drive(1'b1, enc_i(OP_BEQ, 5'd5, 5'd6, 16'hFFFF), 32'h40);
        settle();
        total++; if (bus.branch !== 1'b0) begin bad++; $display("FAIL beq_nofwd got=%0h exp=0", bus.branch); end
        bus.exMemRegWrite = 1'b1;
        bus.exMemRd       = 5'd6;
        bus.exMemResult   = 32'd7;
        settle();
        total++; if (bus.branch !== 1'b1) begin bad++; $display("FAIL beq_fwd_taken got=%0h exp=1", bus.branch); end
        total++; if (bus.branchProgramCounter !== 32'h3C) begin bad++; $display("FAIL beq_target got=%0h exp=3c", bus.branchProgramCounter); end
        tick();
        bus.exMemRegWrite = 1'b0;
        total++; if ({bus.idExValid, bus.calculationControl} !== 5'b10001) begin bad++;
            $display("FAIL beq_issue got=%b exp=10001", {bus.idExValid, bus.calculationControl}); end
        drive(1'b1, enc_r(5'd1, 5'd1, 5'd7), 32'h44);
        settle();
        total++; if ({bus.branch, bus.pcWrite} !== 2'b01) begin bad++; $display("FAIL flush_slot_ctl got=%b exp=01", {bus.branch, bus.pcWrite}); end
        tick();
        total++; if (bus.idExValid !== 1'b0) begin bad++; $display("FAIL flush_bubble got=%0h exp=0", bus.idExValid); end
        tick();
        total++; if (bus.idExValid !== 1'b1) begin bad++; $display("FAIL flush_cleared got=%0h exp=1", bus.idExValid); end
    endtask

    task automatic test_bne();
        idle(1);
        wr_reg(5'd8, 32'h55);
        drive(1'b1, enc_i(OP_BNE, 5'd8, 5'd8, 16'd4), 32'h200);
        settle();
        total++; if (bus.branch !== 1'b0) begin bad++; $display("FAIL bne_equal got=%0h exp=0", bus.branch); end
        tick();
        drive(1'b1, enc_r(5'd1, 5'd1, 5'd7), 32'h204);
        tick();
        total++; if (bus.idExValid !== 1'b1) begin bad++; $display("FAIL bne_noflush got=%0h exp=1", bus.idExValid); end
        drive(1'b1, enc_i(OP_BNE, 5'd8, 5'd5, 16'd4), 32'h300);
        settle();
        total++; if ({bus.branch, bus.branchProgramCounter} !== {1'b1, 32'h310}) begin bad++;
            $display("FAIL bne_taken got=%0h exp=%0h", {bus.branch, bus.branchProgramCounter}, {1'b1, 32'h310}); end
        tick();
        idle(1);
    endtask

    task automatic test_write_through();
        drive(1'b1, enc_r(5'd9, 5'd0, 5'd10), 32'h400);
        bus.regWrite      = 1'b1;
        bus.writeRegister = 5'd9;
        bus.writeData     = 32'hDEADBEEF;
        tick();
        bus.regWrite = 1'b0;
        total++; if ({bus.readData1, bus.readData2} !== {32'hDEADBEEF, 32'h0}) begin bad++;
            $display("FAIL wt_bypass got=%0h exp=%0h", {bus.readData1, bus.readData2}, {32'hDEADBEEF, 32'h0}); end
        drive(1'b1, enc_r(5'd0, 5'd9, 5'd11), 32'h404);
        bus.regWrite      = 1'b1;
        bus.writeRegister = 5'd0;
        bus.writeData     = 32'h1234;
        tick();
        bus.regWrite = 1'b0;
        total++; if ({bus.readData1, bus.readData2} !== {32'h0, 32'hDEADBEEF}) begin bad++;
            $display("FAIL wt_r0_bypass got=%0h exp=%0h", {bus.readData1, bus.readData2}, {32'h0, 32'hDEADBEEF}); end
        tick();
        total++; if (bus.readData1 !== 32'h0) begin bad++; $display("FAIL wt_r0_stored got=%0h exp=0", bus.readData1); end
    endtask

    task automatic test_branch_alu_hazard();
        idle(1);
        drive(1'b1, enc_r(5'd1, 5'd1, 5'd12), 32'h500);
        tick();
        drive(1'b1, enc_i(OP_BEQ, 5'd12, 5'd12, 16'd1), 32'h504);
        settle();
        total++; if ({bus.pcWrite, bus.branch} !== 2'b00) begin bad++; $display("FAIL balu_stall got=%b exp=00", {bus.pcWrite, bus.branch}); end
        tick();
        total++; if (bus.idExValid !== 1'b0) begin bad++; $display("FAIL balu_bubble got=%0h exp=0", bus.idExValid); end
        total++; if ({bus.branch, bus.branchProgramCounter} !== {1'b1, 32'h508}) begin bad++;
            $display("FAIL balu_resolve got=%0h exp=%0h", {bus.branch, bus.branchProgramCounter}, {1'b1, 32'h508}); end
        tick();
        idle(1);
    endtask

    task automatic test_stall_mid_flush();
        idle(1);
        drive(1'b1, enc_i(OP_BEQ, 5'd5, 5'd5, 16'd2), 32'h80);
        settle();
        total++; if ({bus.branch, bus.branchProgramCounter} !== {1'b1, 32'h88}) begin bad++;
            $display("FAIL stall_br got=%0h exp=%0h", {bus.branch, bus.branchProgramCounter}, {1'b1, 32'h88}); end
        tick();
        drive(1'b1, enc_r(5'd1, 5'd1, 5'd11), 32'h84);
        bus.stallIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++; if ({bus.branch, bus.pcWrite, bus.ifIdWrite} !== 3'b000) begin bad++;
                $display("FAIL stall_ctl%0d got=%b exp=000", i, {bus.branch, bus.pcWrite, bus.ifIdWrite}); end
            tick();
            total++; if ({bus.idExValid, bus.calculationControl, bus.programCounterOut} !== {1'b1, 4'b0001, 32'h80}) begin bad++;
                $display("FAIL stall_hold%0d got=%0h exp=%0h", i, {bus.idExValid, bus.calculationControl, bus.programCounterOut}, {1'b1, 4'b0001, 32'h80}); end
        end
        bus.stallIn = 1'b0;
        settle();
        total++; if (bus.pcWrite !== 1'b1) begin bad++; $display("FAIL stall_release got=%0h exp=1", bus.pcWrite); end
        tick();
        total++; if (bus.idExValid !== 1'b0) begin bad++; $display("FAIL stall_bubble got=%0h exp=0", bus.idExValid); end
        tick();
        total++; if ({bus.idExValid, bus.calculationControl, bus.programCounterOut} !== {1'b1, 4'b1010, 32'h84}) begin bad++;
            $display("FAIL stall_after got=%0h exp=%0h", {bus.idExValid, bus.calculationControl, bus.programCounterOut}, {1'b1, 4'b1010, 32'h84}); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.ifIdValid        = 1'b0;
        bus.programCounterIn = '0;
        bus.instruction      = '0;
        bus.stallIn          = 1'b0;
        bus.writeRegister    = '0;
        bus.writeData        = '0;
        bus.regWrite         = 1'b0;
        bus.exMemRegWrite    = 1'b0;
        bus.exMemRd          = '0;
        bus.exMemResult      = '0;
        test_reset();
        test_load_use();
        test_beq_forward();
        test_bne();
        test_write_through();
        test_branch_alu_hazard();
        test_stall_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
- Parametrised successor to the current decode stage of the 5-stage pipeline; sits between the IF/ID and ID/EX boundaries.
- Reads operands from an internal register file and decodes control fields.
- Resolves BEQ/BNE in ID, using EX/MEM forwarding for the branch compare.
- Detects load-use hazards, flushes the slot after a taken branch, honours an external memory stall, and drives a valid-tagged ID/EX register with synchronous reset.

Parameters:
- DATA_WIDTH, 32, operand/PC width.
- REG_ADDR_WIDTH, 5, register index width; register count = 2**REG_ADDR_WIDTH.
- IMM_WIDTH, 16, immediate field width, sign-extended to DATA_WIDTH.
- BRANCH_SHIFT, 2, left shift applied to the immediate for the branch target.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- ifIdValid  in  1  instruction input is a real instruction.
- programCounterIn  in  DATA_WIDTH  PC+4 of the instruction in ID.
- instruction  in  32  raw instruction.
- stallIn  in  1  downstream memory stall; freezes this stage.
- writeRegister  in  REG_ADDR_WIDTH  write-back destination.
- writeData  in  DATA_WIDTH  write-back data.
- regWrite  in  1  write-back enable.
- exMemRegWrite  in  1  EX/MEM writes a register.
- exMemRd  in  REG_ADDR_WIDTH  EX/MEM destination.
- exMemResult  in  DATA_WIDTH  EX/MEM ALU result.
- idExValid  out  1  ID/EX holds a real instruction.
- writeBackControl  out  2  {regWrite, memToReg}.
- memAccessControl  out  2  {memRead, memWrite}.
- calculationControl  out  4  {regDst, aluSrc, aluOp[1:0]}.
- programCounterOut  out  DATA_WIDTH  registered PC.
- readData1, readData2  out  DATA_WIDTH  registered operands.
- immediateOperand  out  DATA_WIDTH  registered sign-extended immediate.
- rs, rt, rd  out  REG_ADDR_WIDTH  registered register fields.
- pcWrite, ifIdWrite  out  1  upstream write enables (0 = hold).
- branch  out  1  taken branch this cycle.
- branchProgramCounter  out  DATA_WIDTH  branch target.

Behaviour:
- **Reset.** All ID/EX outputs clear to 0 on the first clk edge with reset high, including idExValid and the internal flushNext flag. Register file contents are not reset; register 0 reads 0 and its writes are ignored.
- **Register file write/read.** The write occurs on the rising edge. A same-cycle read of the register being written returns writeData (write-through bypass).
- **Compare operands.** For each source, if exMemRegWrite is set, exMemRd equals that source, and exMemRd is nonzero, the compare uses exMemResult. Otherwise it uses the bypassed register file value.
- **Load-use hazard.** A hazard exists when idExValid, memAccessControl[1], rt≠0, and rt equals currentRs or currentRt.
  - Hazard → pcWrite=0 and ifIdWrite=0; a bubble is inserted.
- **Branch-on-ALU hazard.** A branch whose source matches an idExValid writer in ID/EX, with rd/rt≠0, also stalls one cycle.
- **Branch.** branch = decoded branch & ifIdValid & ~flushNext & ~hazard & ~stallIn.
  - BEQ is taken on equal; BNE is taken on not-equal.
  - branchProgramCounter = programCounterIn + (signext(imm) << BRANCH_SHIFT), truncated modulo 2**DATA_WIDTH.
- **Flush.** flushNext is set on the edge where branch=1 and cleared on the next non-stalled edge. While it is set, the slot enters ID/EX as a bubble.
- **Bubble.** A bubble clears idExValid and all three control fields; data fields still load.
- **stallIn.** stallIn=1 has priority over everything except reset: ID/EX and flushNext hold, pcWrite=ifIdWrite=0, branch=0.
- **ifIdValid=0.** The slot is treated as a bubble; no hazard or branch is raised.
- **Unknown opcode.** All controls are 0 but idExValid=1 (NOP).
- **Latency.** One cycle from ID to ID/EX outputs.

Decomposition:
- Package decode_pkg holds:
  - opcode constants: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000;
  - control field widths and bit positions;
  - the bubble control constant.
- Sub-module decode_control: combinational opcode→control table plus branch/isBne decode.
- The register file is a second instance, register_file_param, with write-through.

Test Plan:
1. **Reset.** reset high for 2 cycles with a random instruction → all outputs 0, idExValid=0; on release, ADDI r1,r0,5 gives calculationControl=0110, immediateOperand=5, idExValid=1.
2. **Load-use.** LW r2 in ID/EX with ADD r3,r2,r4 in ID → pcWrite=ifIdWrite=0 for 1 cycle, a bubble (controls 0), then the ADD issues.
3. **BEQ forwarded taken.** BEQ r5,r6,imm=-1 with PCin=0x40, r5=7, exMemRd=6, exMemResult=7 → branch=1, target 0x3C; next slot bubbled.
4. **BNE equal, not taken.** BNE with equal operands → branch=0, no flush.
5. **Write-through.** Write r9=0xDEADBEEF in the same cycle that ID reads r9 → readData1=0xDEADBEEF next edge. A write to r0 still reads 0.
6. **stallIn mid-flush.** Raise stallIn 3 cycles right after a taken branch → outputs hold, branch=0, flushNext kept; the bubble is still inserted after release.
